// File: rtl/gray_rate_meter.sv
`default_nettype none
// ============================================================================
// gray_rate_meter: synchronises a foreign-domain Gray count into clk and
// publishes the binary increment total once per gate window.
// Optional build macro: GRAY_RATE_STEP_CHECK_EN (Gray step-error counter).
// Revision: 1.0
// ============================================================================
module gray_rate_meter #(
   parameter int unsigned GW   = 4,
   parameter int unsigned CW   = 28,
   parameter int unsigned GATE = 1000000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [GW-1:0] gray_in,
   output logic [CW-1:0] rate,
   output logic          rate_stb,
   output logic          ovf,
   output logic [7:0]    err_cnt
);

   localparam int unsigned   SW    = ((CW > GW) ? CW : GW) + 1;
   localparam logic [SW-1:0] c_sat = {{(SW-CW){1'b0}}, {CW{1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [GW-1:0] cur_q, cur_d, prv_q, prv_d;
   logic [CW-1:0] acc_q, acc_d, rate_q, rate_d;
   logic [31:0]   gcnt_q, gcnt_d;
   logic          wovf_q, wovf_d, ovf_q, ovf_d, stb_q, stb_d, fresh_q, fresh_d;

   logic [GW-1:0] bin;
   logic [GW-1:0] delta;
   logic [SW-1:0] sum;
   logic          sat_now;
   logic [CW-1:0] acc_sat;

   always_comb begin
      bin[GW-1] = s2_q[GW-1];
      for (int i = int'(GW) - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ s2_q[i];
      end
   end

   assign delta   = cur_q - prv_q;
   assign sum     = {{(SW-CW){1'b0}}, acc_q} + {{(SW-GW){1'b0}}, delta};
   assign sat_now = (sum > c_sat);
   assign acc_sat = sat_now ? {CW{1'b1}} : sum[CW-1:0];

   always_comb begin
      state_d = state_q;
      s1_d    = gray_in;
      s2_d    = s1_q;
      cur_d   = bin;
      prv_d   = prv_q;
      acc_d   = acc_q;
      rate_d  = rate_q;
      gcnt_d  = gcnt_q;
      wovf_d  = wovf_q;
      ovf_d   = ovf_q;
      stb_d   = 1'b0;
      fresh_d = fresh_q;
      case (state_q)
         IDLE: begin
            state_d = PRIME;
         end
         PRIME: begin
            prv_d   = cur_q;
            gcnt_d  = 32'd0;
            fresh_d = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            // The sync pipeline still holds reset zeros when RUN begins; snap prv
            // to the first real sample so the upstream start value is not counted.
            prv_d   = fresh_q ? bin : cur_q;
            fresh_d = 1'b0;
            if (gcnt_q == GATE - 1) begin
               rate_d = acc_sat;
               ovf_d  = wovf_q | sat_now;
               acc_d  = '0;
               wovf_d = 1'b0;
               stb_d  = 1'b1;
               gcnt_d = 32'd0;
            end else begin
               acc_d  = acc_sat;
               wovf_d = wovf_q | sat_now;
               gcnt_d = gcnt_q + 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s1_q    <= '0;
         s2_q    <= '0;
         cur_q   <= '0;
         prv_q   <= '0;
         acc_q   <= '0;
         rate_q  <= '0;
         gcnt_q  <= 32'd0;
         wovf_q  <= 1'b0;
         ovf_q   <= 1'b0;
         stb_q   <= 1'b0;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         cur_q   <= cur_d;
         prv_q   <= prv_d;
         acc_q   <= acc_d;
         rate_q  <= rate_d;
         gcnt_q  <= gcnt_d;
         wovf_q  <= wovf_d;
         ovf_q   <= ovf_d;
         stb_q   <= stb_d;
         fresh_q <= fresh_d;
      end
   end

   assign rate     = rate_q;
   assign rate_stb = stb_q;
   assign ovf      = ovf_q;

`ifdef GRAY_RATE_STEP_CHECK_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == RUN) && (delta > GW'(1)) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 8'd0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_rate_meter.sv
`default_nettype none
// ============================================================================
// tb_gray_rate_meter: directed checks of window timing, rate values,
// saturation, mid-window reset and the optional step-error counter.
// Revision: 1.0
// ============================================================================
module tb_gray_rate_meter;

   localparam int unsigned GW   = 4;
   localparam int unsigned CW   = 5;
   localparam int unsigned GATE = 100;

`ifdef GRAY_RATE_STEP_CHECK_EN
   localparam int E_FEW  = 4;
   localparam int E_MANY = 255;
`else
   localparam int E_FEW  = 0;
   localparam int E_MANY = 0;
`endif

   logic          clk;
   logic          rst_n;
   logic [GW-1:0] gray_in;
   logic [CW-1:0] rate;
   logic          rate_stb;
   logic          ovf;
   logic [7:0]    err_cnt;

   gray_rate_meter #(.GW(GW), .CW(CW), .GATE(GATE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .gray_in  (gray_in),
      .rate     (rate),
      .rate_stb (rate_stb),
      .ovf      (ovf),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source model: binary count src, presented as Gray.
   logic [31:0] src = 32'd12;
   int          period = 0;
   int          ph = 0;
   int          jumps_req = 0;
   int          jumps_done = 0;
   bit          jph = 1'b0;

   function automatic logic [GW-1:0] b2g(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign gray_in = b2g(src[GW-1:0]);

   always @(negedge clk) begin
      if (jumps_done < jumps_req) begin
         jph = ~jph;
         if (jph) begin
            src = src + 32'd3;
            jumps_done++;
         end
      end else if (period != 0) begin
         ph++;
         if (ph >= period) begin
            ph  = 0;
            src = src + 32'd1;
         end
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rate_stb && n < 400);
   endtask

   typedef struct {
      int period;
      int exp_rate;
      int exp_ovf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sum;
      int diff;
      logic [31:0] s0;

      vecs[0] = '{4, 25, 0};
      vecs[1] = '{2, 31, 1};
      vecs[2] = '{5, 20, 0};
      vecs[3] = '{0, 0, 0};
      vecs[4] = '{10, 10, 0};
      vecs[5] = '{4, 25, 0};
      vecs[6] = '{1, 31, 1};

      // Reset state, with upstream sitting at a non-zero Gray value (1010).
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rate", int'(rate), 0);
      check("rst_stb", int'(rate_stb), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_err", int'(err_cnt), 0);
      check("src_gray_1010", int'(gray_in), 10);

      rst_n = 1'b1;
      wait_strobe(n);
      check("first_strobe_cycle", n, GATE + 2);
      check("static_rate_w1", int'(rate), 0);
      check("static_err_w1", int'(err_cnt), 0);
      @(posedge clk);
      #1;
      check("strobe_one_cycle", int'(rate_stb), 0);
      wait_strobe(n);
      check("static_strobe_gap", n, GATE - 1);
      check("static_rate_w2", int'(rate), 0);

      foreach (vecs[i]) begin
         period = vecs[i].period;
         wait_strobe(n);
         check($sformatf("vec%0d_settle_gap", i), n, GATE);
         wait_strobe(n);
         check($sformatf("vec%0d_gap", i), n, GATE);
         check($sformatf("vec%0d_rate", i), int'(rate), vecs[i].exp_rate);
         check($sformatf("vec%0d_ovf", i), int'(ovf), vecs[i].exp_ovf);
         check($sformatf("vec%0d_err", i), int'(err_cnt), 0);
      end

      // Mid-window asynchronous reset, then restart via IDLE/PRIME.
      repeat (59) @(posedge clk);
      #3;
      check("hold_rate_midwin", int'(rate), 31);
      check("hold_ovf_midwin", int'(ovf), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_rate", int'(rate), 0);
      check("async_rst_ovf", int'(ovf), 0);
      check("async_rst_stb", int'(rate_stb), 0);
      period = 4;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_strobe(n);
      check("rerst_strobe_cycle", n, GATE + 2);
      check("rerst_rate_24_or_25", int'(rate == 5'd24 || rate == 5'd25), 1);
      check("rerst_ovf", int'(ovf), 0);
      wait_strobe(n);
      check("rerst_rate_w2", int'(rate), 25);

      // Conservation across window boundaries with a non-dividing period.
      period = 7;
      wait_strobe(n);
      s0  = src;
      sum = 0;
      for (int w = 0; w < 6; w++) begin
         wait_strobe(n);
         sum += int'(rate);
      end
      diff = sum - int'(src - s0);
      check("conserve_within_1", int'(diff >= -1 && diff <= 1), 1);

      // Step-error injection.
      period = 0;
      jumps_req = jumps_req + 4;
      repeat (20) @(posedge clk);
      #1;
      check("err_after_4_jumps", int'(err_cnt), E_FEW);
      jumps_req = jumps_req + 300;
      repeat (700) @(posedge clk);
      #1;
      check("err_after_304_jumps", int'(err_cnt), E_MANY);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
